ttl_update: RTL and testbench
=============================

TTL_UPDATE -- requirements
Module: ttl_update

Interface
REQ-001 Param C_S_AXI_DATA_WIDTH, 32: counter and control register width.
REQ-002 Param C_M_AXIS_DATA_WIDTH / C_S_AXIS_DATA_WIDTH, 256: stream data width; both SHALL be equal.
REQ-003 Param C_M_AXIS_TUSER_WIDTH / C_S_AXIS_TUSER_WIDTH, 128: sideband width.
REQ-004 Param SRC_PORT_POS, 16 / DST_PORT_POS, 24: LSB of the 8-bit one-hot source and destination port fields in TUSER.
REQ-005 AXI_ACLK  in  1  sole clock; all logic is rising-edge.
REQ-006 AXI_RESET  in  1  asynchronous, active-high reset.
REQ-007 S_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  in  256/32/128/1/1  upstream stream, fed by the packet-drop stage.
REQ-008 S_AXIS_TREADY  out  1  upstream backpressure.
REQ-009 M_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  out  256/32/128/1/1  downstream stream.
REQ-010 M_AXIS_TREADY  in  1  downstream backpressure.
REQ-011 reset  in  32  counter clear; active when value == 1.
REQ-012 ipv4_fwd_count  out  32  IPv4 packets forwarded with decremented TTL.
REQ-013 ttl_expired_count  out  32  IPv4 packets with TTL <= 1, redirected to CPU.

Function
REQ-014 Header beat layout: ethertype [159:144], TTL [79:72], IP checksum [63:48]; all other header fields SHALL pass unmodified.
REQ-015 One-entry output register: S_AXIS_TREADY = !M_AXIS_TVALID || M_AXIS_TREADY; a beat is accepted when S_AXIS_TVALID && S_AXIS_TREADY.
REQ-016 Latency SHALL be exactly 1 cycle from acceptance to M_AXIS_TVALID; throughput 1 beat/cycle with M_AXIS_TREADY held high.
REQ-017 While M_AXIS_TVALID && !M_AXIS_TREADY, all M_AXIS outputs SHALL stay stable.
REQ-018 FSM states: WAIT_HDR and IN_PKT.
REQ-019 WAIT_HDR -> IN_PKT on an accepted beat with TLAST=0; an accepted beat with TLAST=1 keeps WAIT_HDR (single-beat packet).
REQ-020 IN_PKT -> WAIT_HDR on an accepted beat with TLAST=1; no transition on non-accepted cycles.
REQ-021 Only the beat accepted in WAIT_HDR is modified; IN_PKT beats pass bit-exact.
REQ-022 Header beat, ethertype == 0x0800, TTL > 1: TTL' = TTL-1 and csum' = csum + 0x0100 with end-around carry (17-bit sum, carry folded into bit 0); ipv4_fwd_count += 1.
REQ-023 Header beat, ethertype == 0x0800, TTL <= 1 (0 included): data unchanged; TUSER[DST_PORT_POS+:8] = TUSER[SRC_PORT_POS+:8] << 1 (CPU port of ingress port); ttl_expired_count += 1.
REQ-024 Non-IPv4 header beat: passes unchanged; no counter changes.
REQ-025 Counters increment at header-beat acceptance and wrap at 2^32.
REQ-026 If reset == 1 and an increment occur in the same cycle, the clear SHALL win.
REQ-027 TSTRB and TLAST SHALL pass through unmodified, registered with their beat.

Reset
REQ-028 AXI_RESET SHALL immediately force: M_AXIS_TVALID=0, state=WAIT_HDR, both counters=0; data registers 0.
REQ-029 A reset asserted mid-packet SHALL discard the in-flight beat; the next accepted beat after release is treated as a header.
REQ-030 S_AXIS_TREADY SHALL read 1 while in reset, since M_AXIS_TVALID=0.

Structure
REQ-031 Shared package: ETHERTYPE_IPV4 = 16'h0800, header bit-offset constants, and the one's-complement add function.
REQ-032 Single module, no sub-module; the checksum adder is a package function, not an instance.

Verification
REQ-033 IPv4 header TTL=0x40, csum=0xB1E6, 2-beat packet -> out TTL=0x3F, csum=0xB2E6, beat 2 bit-exact, ipv4_fwd_count=1.
REQ-034 IPv4 TTL=0x80, csum=0xFF10 -> csum'=0x0011 (carry wrap), TTL'=0x7F.
REQ-035 IPv4 TTL=0x01, TUSER[23:16]=0x04 -> TUSER[31:24]=0x08, TDATA unchanged, ttl_expired_count=1, ipv4_fwd_count unchanged.
REQ-036 Ethertype 0x0806, 3-beat packet -> all beats bit-exact, both counters unchanged.
REQ-037 Back-to-back packets with M_AXIS_TREADY low for 5 cycles mid-packet -> outputs held stable, no beat lost or duplicated, S_AXIS_TREADY=0 while full.
REQ-038 AXI_RESET pulsed during beat 2 of 4, then a fresh packet -> M_AXIS_TVALID drops immediately, counters=0, the fresh packet's first beat is modified as a header.

Source files
------------

// File: rtl/ttl_update_pkg.sv
// ttl_update_pkg: shared constants and helpers
// for the TTL update stage.
package ttl_update_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

  localparam int ETH_TYPE_LSB = 144;
  localparam int TTL_LSB      = 72;
  localparam int CSUM_LSB     = 48;

  localparam logic [15:0] CSUM_TTL_ADJ = 16'h0100;

  // One's-complement 16-bit add with end-around carry.
  function automatic logic [15:0] ones_add16(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ttl_update.sv
// ttl_update: decrements IPv4 TTL on header beats,
// patches the checksum and redirects expired packets.
module ttl_update
  import ttl_update_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     reset,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     ipv4_fwd_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     ttl_expired_count
);

  localparam logic [0:0] WAIT_HDR = 1'b0;
  localparam logic [0:0] IN_PKT   = 1'b1;

  localparam int DW = C_M_AXIS_DATA_WIDTH;
  localparam int UW = C_M_AXIS_TUSER_WIDTH;
  localparam int CW = C_S_AXI_DATA_WIDTH;

  localparam logic [CW-1:0] CNT_ONE = 1;

  logic [0:0]    state_q, state_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic [DW-1:0] tdata_q, tdata_d;
  logic [DW/8-1:0] tstrb_q, tstrb_d;
  logic [UW-1:0] tuser_q, tuser_d;
  logic [CW-1:0] fwd_q, fwd_d;
  logic [CW-1:0] exp_q, exp_d;

  logic          s_ready;
  logic          accept;
  logic          is_hdr;
  logic          is_ipv4;
  logic          ttl_live;
  logic [7:0]    ttl_in;
  logic [15:0]   csum_in;
  logic [DW-1:0] mod_data;
  logic [UW-1:0] mod_user;

  // Header classification and field rewrite for the incoming beat.
  always_comb begin
    s_ready  = !tvalid_q || M_AXIS_TREADY;
    accept   = S_AXIS_TVALID && s_ready;
    is_hdr   = (state_q == WAIT_HDR);
    ttl_in   = S_AXIS_TDATA[TTL_LSB +: 8];
    csum_in  = S_AXIS_TDATA[CSUM_LSB +: 16];
    is_ipv4  = (S_AXIS_TDATA[ETH_TYPE_LSB +: 16] == ETHERTYPE_IPV4);
    ttl_live = (ttl_in > 8'd1);
    mod_data = S_AXIS_TDATA;
    mod_user = S_AXIS_TUSER;
    if (is_hdr && is_ipv4) begin
      if (ttl_live) begin
        mod_data[TTL_LSB +: 8]   = ttl_in - 8'd1;
        mod_data[CSUM_LSB +: 16] = ones_add16(csum_in, CSUM_TTL_ADJ);
      end else begin
        mod_user[DST_PORT_POS +: 8] =
          {S_AXIS_TUSER[SRC_PORT_POS +: 7], 1'b0};
      end
    end
  end

  // Packet framing and one-entry output register next state.
  always_comb begin
    state_d  = state_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    tstrb_d  = tstrb_q;
    tuser_d  = tuser_q;
    if (accept) begin
      state_d  = S_AXIS_TLAST ? WAIT_HDR : IN_PKT;
      tvalid_d = 1'b1;
      tlast_d  = S_AXIS_TLAST;
      tdata_d  = mod_data;
      tstrb_d  = S_AXIS_TSTRB;
      tuser_d  = mod_user;
    end else if (M_AXIS_TREADY) begin
      tvalid_d = 1'b0;
    end
  end

  // Statistics counters; a clear request overrides an increment.
  always_comb begin
    fwd_d = fwd_q;
    exp_d = exp_q;
    if (accept && is_hdr && is_ipv4) begin
      if (ttl_live) fwd_d = fwd_q + CNT_ONE;
      else          exp_d = exp_q + CNT_ONE;
    end
    if (reset == CNT_ONE) begin
      fwd_d = '0;
      exp_d = '0;
    end
  end

  // State, output register and counter flops.
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      state_q  <= WAIT_HDR;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tstrb_q  <= '0;
      tuser_q  <= '0;
      fwd_q    <= '0;
      exp_q    <= '0;
    end else begin
      state_q  <= state_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      tstrb_q  <= tstrb_d;
      tuser_q  <= tuser_d;
      fwd_q    <= fwd_d;
      exp_q    <= exp_d;
    end
  end

  assign S_AXIS_TREADY     = s_ready;
  assign M_AXIS_TVALID     = tvalid_q;
  assign M_AXIS_TLAST      = tlast_q;
  assign M_AXIS_TDATA      = tdata_q;
  assign M_AXIS_TSTRB      = tstrb_q;
  assign M_AXIS_TUSER      = tuser_q;
  assign ipv4_fwd_count    = fwd_q;
  assign ttl_expired_count = exp_q;

endmodule

// File: tb/tb_ttl_update.sv
// tb_ttl_update: random and directed stimulus against
// a packet-level reference model.
module tb_ttl_update;

  typedef struct packed {
    logic [255:0] d;
    logic [127:0] u;
    logic [31:0]  s;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] s_tdata;
  logic [31:0]  s_tstrb;
  logic [127:0] s_tuser;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready;
  logic [31:0]  cnt_clr;
  logic [31:0]  fwd_cnt;
  logic [31:0]  exp_cnt;

  ttl_update dut (
    .AXI_ACLK          (clk),
    .AXI_RESET         (rst),
    .S_AXIS_TDATA      (s_tdata),
    .S_AXIS_TSTRB      (s_tstrb),
    .S_AXIS_TUSER      (s_tuser),
    .S_AXIS_TVALID     (s_tvalid),
    .S_AXIS_TLAST      (s_tlast),
    .S_AXIS_TREADY     (s_tready),
    .M_AXIS_TDATA      (m_tdata),
    .M_AXIS_TSTRB      (m_tstrb),
    .M_AXIS_TUSER      (m_tuser),
    .M_AXIS_TVALID     (m_tvalid),
    .M_AXIS_TLAST      (m_tlast),
    .M_AXIS_TREADY     (m_tready),
    .reset             (cnt_clr),
    .ipv4_fwd_count    (fwd_cnt),
    .ttl_expired_count (exp_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  beat_t src_q[$];
  beat_t exp_q[$];

  logic [31:0] m_fwd = 0;
  logic [31:0] m_exp = 0;

  int cyc     = 0;
  int vld_pct = 100;
  int rdy_rnd = 0;
  int st_lo   = -1;
  int st_hi   = -1;
  logic s_hold = 1'b0;
  logic stalled = 1'b0;
  beat_t held;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Expected header beat from the forwarding rules.
  task automatic ref_hdr(input beat_t b, output beat_t e);
    int ttl;
    int cs;
    e = b;
    if (b.d[159:144] == 16'h0800) begin
      ttl = int'(b.d[79:72]);
      if (ttl > 1) begin
        cs = int'(b.d[63:48]) + 256;
        if (cs > 65535) cs = cs - 65536 + 1;
        e.d[79:72] = 8'(ttl - 1);
        e.d[63:48] = 16'(cs);
        m_fwd = m_fwd + 1;
      end else begin
        e.u[31:24] = 8'((int'(b.u[23:16]) * 2) % 256);
        m_exp = m_exp + 1;
      end
    end
  endtask

  task automatic push(input beat_t b, input beat_t e);
    src_q.push_back(b);
    exp_q.push_back(e);
  endtask

  function automatic beat_t mk(input logic [255:0] d,
                               input logic l);
    beat_t b;
    b.d = d;
    b.u = rnd128();
    b.s = $urandom;
    b.l = l;
    return b;
  endfunction

  function automatic beat_t hdr(input logic [15:0] et,
                                input logic [7:0] ttl,
                                input logic [15:0] cs,
                                input logic l);
    beat_t b;
    b = mk(rnd256(), l);
    b.d[159:144] = et;
    b.d[79:72]   = ttl;
    b.d[63:48]   = cs;
    return b;
  endfunction

  task automatic rand_pkt();
    int n;
    int k;
    logic [7:0] ttl;
    beat_t b;
    beat_t e;
    n = $urandom_range(1, 4);
    k = $urandom_range(0, 4);
    ttl = (k == 0) ? 8'd0 : (k == 1) ? 8'd1 :
          (k == 2) ? 8'd2 : 8'($urandom);
    b = hdr(($urandom_range(0, 3) != 0) ? 16'h0800 : 16'($urandom),
            ttl, 16'($urandom), n == 1);
    ref_hdr(b, e);
    push(b, e);
    for (int i = 1; i < n; i++) begin
      b = mk(rnd256(), i == n - 1);
      push(b, b);
    end
  endtask

  task automatic drive();
    if (!s_hold) begin
      if (src_q.size() > 0 &&
          $urandom_range(0, 99) < vld_pct) begin
        s_tvalid = 1'b1;
        s_tdata  = src_q[0].d;
        s_tuser  = src_q[0].u;
        s_tstrb  = src_q[0].s;
        s_tlast  = src_q[0].l;
      end else begin
        s_tvalid = 1'b0;
        s_tdata  = rnd256();
        s_tlast  = $urandom_range(0, 1);
      end
    end
    m_tready = 1'b1;
    if (rdy_rnd != 0) m_tready = ($urandom_range(0, 9) < 7);
    if (cyc >= st_lo && cyc < st_hi) m_tready = 1'b0;
  endtask

  task automatic observe();
    beat_t e;
    cyc++;
    if (stalled) begin
      chk("hold_data", m_tdata, held.d);
      chk("hold_user", m_tuser, held.u);
      chk("hold_misc", {m_tvalid, m_tlast, m_tstrb},
          {1'b1, held.l, held.s});
    end
    stalled = m_tvalid && !m_tready;
    if (stalled) begin
      held = '{m_tdata, m_tuser, m_tstrb, m_tlast};
      chk("tready_full", s_tready, 0);
    end
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("tdata", m_tdata, e.d);
        chk("tuser", m_tuser, e.u);
        chk("tstrb", m_tstrb, e.s);
        chk("tlast", m_tlast, e.l);
      end
    end
    if (s_tvalid && s_tready) begin
      void'(src_q.pop_front());
      s_hold = 1'b0;
    end else begin
      s_hold = s_tvalid;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    observe();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0 || m_tvalid)
           && n < budget) begin
      step();
      n++;
    end
    chk("drain_left", src_q.size() + exp_q.size(), 0);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_fwd"}, fwd_cnt, m_fwd);
    chk({tag, "_exp"}, exp_cnt, m_exp);
  endtask

  beat_t b;
  beat_t e;

  initial begin
    rst      = 1'b1;
    cnt_clr  = 0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tuser  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    #3;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tready", s_tready, 1);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_cnt", {fwd_cnt, exp_cnt}, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // TTL 0x40 decrement, two-beat packet
    b = hdr(16'h0800, 8'h40, 16'hB1E6, 1'b0);
    e = b;
    e.d[79:72] = 8'h3F;
    e.d[63:48] = 16'hB2E6;
    push(b, e);
    b = mk(rnd256(), 1'b1);
    push(b, b);
    drain(50);
    chk("t033_fwd", fwd_cnt, 1);
    m_fwd = 1;

    // checksum end-around carry
    b = hdr(16'h0800, 8'h80, 16'hFF10, 1'b1);
    e = b;
    e.d[79:72] = 8'h7F;
    e.d[63:48] = 16'h0011;
    push(b, e);
    m_fwd = m_fwd + 1;
    drain(50);

    // expired TTL goes to CPU port
    b = hdr(16'h0800, 8'h01, 16'h1234, 1'b1);
    b.u[23:16] = 8'h04;
    e = b;
    e.u[31:24] = 8'h08;
    push(b, e);
    m_exp = m_exp + 1;
    drain(50);
    chk("t035_exp", exp_cnt, 1);
    chk("t035_fwd", fwd_cnt, 2);

    // ARP passes untouched
    b = hdr(16'h0806, 8'h40, 16'hABCD, 1'b0);
    push(b, b);
    b = mk(rnd256(), 1'b0);
    push(b, b);
    b = mk(rnd256(), 1'b1);
    push(b, b);
    drain(50);
    chk_cnt("t036");

    // back-to-back packets with a 5-cycle stall mid-packet
    for (int p = 0; p < 2; p++) begin
      b = hdr(16'h0800, 8'(8'h10 + p), 16'($urandom), 1'b0);
      ref_hdr(b, e);
      push(b, e);
      for (int i = 1; i < 3; i++) begin
        b = mk(rnd256(), i == 2);
        push(b, b);
      end
    end
    st_lo = cyc + 3;
    st_hi = cyc + 8;
    drain(100);
    chk_cnt("t037");

    // randomized traffic with random backpressure
    vld_pct = 70;
    rdy_rnd = 1;
    for (int p = 0; p < 60; p++) rand_pkt();
    drain(5000);
    chk_cnt("rand");

    // counter clear beats a simultaneous increment
    rdy_rnd = 0;
    vld_pct = 100;
    cnt_clr = 32'd1;
    b = hdr(16'h0800, 8'h09, 16'h0000, 1'b1);
    ref_hdr(b, e);
    push(b, e);
    drain(50);
    m_fwd = 0;
    m_exp = 0;
    chk_cnt("clr");
    cnt_clr = 32'd2;
    b = hdr(16'h0800, 8'h00, 16'h0000, 1'b1);
    ref_hdr(b, e);
    push(b, e);
    drain(50);
    chk_cnt("noclr");
    cnt_clr = 32'd0;

    // reset in the middle of a four-beat packet
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    b = hdr(16'h0800, 8'h10, 16'h0000, 1'b0);
    s_tdata = b.d;
    s_tuser = b.u;
    s_tstrb = b.s;
    s_tlast = 1'b0;
    @(posedge clk);
    #1;
    s_tdata = rnd256();
    chk("pre_rst_tvalid", m_tvalid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", m_tvalid, 0);
    chk("mid_rst_tready", s_tready, 1);
    chk("mid_rst_cnt", {fwd_cnt, exp_cnt}, 0);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    rst = 1'b0;
    s_hold = 1'b0;
    stalled = 1'b0;
    m_fwd = 0;
    m_exp = 0;
    b = hdr(16'h0800, 8'h22, 16'h1234, 1'b0);
    e = b;
    e.d[79:72] = 8'h21;
    e.d[63:48] = 16'h1334;
    push(b, e);
    b = mk(rnd256(), 1'b1);
    push(b, b);
    m_fwd = 1;
    drain(50);
    chk_cnt("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
